// File: rtl/key_debounce_pkg.sv
// Shared constants and types for the push-button debouncer.
// Board clock, 1 ms time base, and the default channel configuration.
package key_debounce_pkg;

   localparam int CLK_HZ        = 50_000_000;
   localparam int TICK_HZ       = 1_000;
   localparam int CYCLES_PER_MS = CLK_HZ / TICK_HZ;   // 50_000 clk cycles per tick

   localparam int DEFAULT_N_BTN       = 4;
   localparam int DEFAULT_DEBOUNCE_MS = 20;
   localparam int DEFAULT_CNT_W       = 5;

   // What a channel does to its stable level on a given cycle.
   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_PRESS   = 2'd1,
      EV_RELEASE = 2'd2
   } edge_ev_t;

   // The tick counter must be able to hold DEBOUNCE_MS-1 without wrapping.
   function automatic bit debounce_ms_legal(input int ms, input int cnt_w);
      return (ms >= 1) && (ms <= (1 << cnt_w) - 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, tick qualification counter,
// stable level and registered one-cycle press/release pulses.
module debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_1ms,
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);
   localparam bit               CFG_OK   = debounce_ms_legal(DEBOUNCE_MS, CNT_W);

   logic             sync_meta;
   logic             btn_sync;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   logic             stable_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   edge_ev_t         ev;

   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // otherwise a missed path would hold its old value and infer a latch.
      stable_nxt = stable;
      cnt_nxt    = cnt;
      ev         = EV_NONE;

      if (btn_sync == stable) begin
         // Any agreement, tick or not, restarts qualification.
         cnt_nxt = '0;
      end else if (tick_1ms) begin
         if (cnt == CNT_LAST) begin
            stable_nxt = ~stable;
            cnt_nxt    = '0;
            ev         = stable ? EV_RELEASE : EV_PRESS;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   // NOTE: state registers use <= so every flop samples pre-edge values;
   // blocking here would let the second sync stage see the first stage's new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta     <= 1'b0;
         btn_sync      <= 1'b0;
         stable        <= 1'b0;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_meta     <= raw;
         btn_sync      <= sync_meta;
         stable        <= stable_nxt;
         cnt           <= cnt_nxt;
         press_pulse   <= (ev == EV_PRESS);
         release_pulse <= (ev == EV_RELEASE);
      end
   end

   assign level = stable;

   cfg_legal: assert property (@(posedge clk) CFG_OK);

   pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(press_pulse && release_pulse));

   cnt_bounded: assert property (@(posedge clk) disable iff (rst)
      cnt <= CNT_LAST);

   press_one_cycle: assert property (@(posedge clk) disable iff (rst)
      press_pulse |=> !press_pulse);

   release_one_cycle: assert property (@(posedge clk) disable iff (rst)
      release_pulse |=> !release_pulse);

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: derives the 1 ms tick strobe from the
// clk_1ms square wave and fans it out to N_BTN independent channels.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int N_BTN       = DEFAULT_N_BTN,
   parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_1ms,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             tick_1ms
);

   logic clk_1ms_d;

   // Loaded during reset as well, so a high clk_1ms at reset release is not seen as an edge.
   always_ff @(posedge clk) begin
      clk_1ms_d <= clk_1ms;
   end

   assign tick_1ms = clk_1ms & ~clk_1ms_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .tick_1ms      (tick_1ms),
         .raw           (btn_in[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_MS=3 and a tick every 8 clk.
// Expected pulse cycles are counted from a negedge aligned to the tick-high cycle.
module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_1ms = 1'b1;
   logic [3:0] btn_in = 4'h0;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic       tick_1ms;

   logic       gen_en = 1'b0;
   logic       clk_1ms_q = 1'b1;
   int         div = 0;

   int         n_checks = 0;
   int         n_pass = 0;

   key_debounce #(
      .N_BTN       (4),
      .DEBOUNCE_MS (3),
      .CNT_W       (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_1ms     (clk_1ms),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .tick_1ms    (tick_1ms)
   );

   always #10 clk = ~clk;

   // clk_1ms toggles every 4 clk once enabled; clk_1ms_q is the bench's own copy of the previous level.
   always @(posedge clk) begin
      clk_1ms_q <= clk_1ms;
      if (gen_en) begin
         if (div == 3) begin
            div     <= 0;
            clk_1ms <= ~clk_1ms;
         end else begin
            div <= div + 1;
         end
      end
   end

   // Stops at the first negedge of a cycle in which a tick is high (call it N0).
   task automatic align_tick();
      bit found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (clk_1ms && !clk_1ms_q) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL align_tick: got no tick within 20 cycles, want one");
      else n_pass++;
   endtask

   task automatic settle(input logic [3:0] v);
      btn_in = v;
      repeat (48) @(negedge clk);
   endtask

   task automatic test_reset();
      int bp = -1; logic [3:0] bp_a, bp_e;
      int br = -1; logic [3:0] br_a;
      logic [3:0] ep;
      rst = 1'b1; btn_in = 4'hF; gen_en = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tick_1ms !== 1'b0) $display("FAIL tick_in_reset: got %b want 0", tick_1ms);
      else n_pass++;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000)
         $display("FAIL outs_in_reset: got lvl=%b prs=%b rel=%b want all 0", btn_level, btn_press, btn_release);
      else n_pass++;
      rst = 1'b0; gen_en = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            n_checks++;
            if (tick_1ms !== 1'b0) $display("FAIL tick_after_reset: got %b want 0", tick_1ms);
            else n_pass++;
         end
         ep = (i == 25) ? 4'hF : 4'h0;
         if (btn_press !== ep && bp < 0) begin bp = i; bp_a = btn_press; bp_e = ep; end
         if (btn_release !== 4'h0 && br < 0) begin br = i; br_a = btn_release; end
      end
      n_checks++;
      if (bp >= 0) $display("FAIL reset_press_seq @%0d: got %b want %b", bp, bp_a, bp_e);
      else n_pass++;
      n_checks++;
      if (br >= 0) $display("FAIL reset_release_seq @%0d: got %b want 0000", br, br_a);
      else n_pass++;
      n_checks++;
      if (btn_level !== 4'hF) $display("FAIL reset_level: got %b want 1111", btn_level);
      else n_pass++;
   endtask

   task automatic test_press();
      int bp = -1; logic [3:0] bp_a, bp_e;
      int bl = -1; logic [3:0] bl_a, bl_e;
      int br = -1; logic [3:0] br_a;
      int bt = -1; logic bt_a, bt_e;
      logic [3:0] ep, el;
      logic et;
      settle(4'h0);
      n_checks++;
      if (btn_level !== 4'h0) $display("FAIL press_pre_level: got %b want 0000", btn_level);
      else n_pass++;
      align_tick();
      btn_in = 4'b0001;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         ep = (i == 25) ? 4'b0001 : 4'b0000;
         el = (i >= 25) ? 4'b0001 : 4'b0000;
         et = (i % 8 == 0);
         if (btn_press !== ep && bp < 0) begin bp = i; bp_a = btn_press; bp_e = ep; end
         if (btn_level !== el && bl < 0) begin bl = i; bl_a = btn_level; bl_e = el; end
         if (btn_release !== 4'h0 && br < 0) begin br = i; br_a = btn_release; end
         if (tick_1ms !== et && bt < 0) begin bt = i; bt_a = tick_1ms; bt_e = et; end
      end
      n_checks++;
      if (bp >= 0) $display("FAIL press_ch0_seq @%0d: got %b want %b", bp, bp_a, bp_e);
      else n_pass++;
      n_checks++;
      if (bl >= 0) $display("FAIL press_ch0_level @%0d: got %b want %b", bl, bl_a, bl_e);
      else n_pass++;
      n_checks++;
      if (br >= 0) $display("FAIL press_ch0_release @%0d: got %b want 0000", br, br_a);
      else n_pass++;
      n_checks++;
      if (bt >= 0) $display("FAIL tick_period @%0d: got %b want %b", bt, bt_a, bt_e);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int bb = -1; logic [3:0] bb_a;
      int bp = -1; logic [3:0] bp_a, bp_e;
      int bl = -1; logic [3:0] bl_a, bl_e;
      logic [3:0] ep, el;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (btn_press !== 4'h0 && bb < 0) begin bb = c; bb_a = btn_press; end
         btn_in[1] = ((c / 6) % 2 == 0);
      end
      btn_in[1] = 1'b0;
      align_tick();
      if (btn_press !== 4'h0 && bb < 0) begin bb = 60; bb_a = btn_press; end
      n_checks++;
      if (bb >= 0) $display("FAIL bounce_no_press @%0d: got %b want 0000", bb, bb_a);
      else n_pass++;
      btn_in = 4'b0011;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         ep = (i == 25) ? 4'b0010 : 4'b0000;
         el = (i >= 25) ? 4'b0011 : 4'b0001;
         if (btn_press !== ep && bp < 0) begin bp = i; bp_a = btn_press; bp_e = ep; end
         if (btn_level !== el && bl < 0) begin bl = i; bl_a = btn_level; bl_e = el; end
      end
      n_checks++;
      if (bp >= 0) $display("FAIL bounce_press_seq @%0d: got %b want %b", bp, bp_a, bp_e);
      else n_pass++;
      n_checks++;
      if (bl >= 0) $display("FAIL bounce_level @%0d: got %b want %b", bl, bl_a, bl_e);
      else n_pass++;
   endtask

   task automatic test_release();
      int br = -1; logic [3:0] br_a, br_e;
      int bp = -1; logic [3:0] bp_a;
      int bl = -1; logic [3:0] bl_a, bl_e;
      logic [3:0] er, el;
      align_tick();
      btn_in = 4'b0010;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         er = (i == 25) ? 4'b0001 : 4'b0000;
         el = (i >= 25) ? 4'b0010 : 4'b0011;
         if (btn_release !== er && br < 0) begin br = i; br_a = btn_release; br_e = er; end
         if (btn_press !== 4'h0 && bp < 0) begin bp = i; bp_a = btn_press; end
         if (btn_level !== el && bl < 0) begin bl = i; bl_a = btn_level; bl_e = el; end
      end
      n_checks++;
      if (br >= 0) $display("FAIL release_ch0_seq @%0d: got %b want %b", br, br_a, br_e);
      else n_pass++;
      n_checks++;
      if (bp >= 0) $display("FAIL release_no_press @%0d: got %b want 0000", bp, bp_a);
      else n_pass++;
      n_checks++;
      if (bl >= 0) $display("FAIL release_level @%0d: got %b want %b", bl, bl_a, bl_e);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      int bp = -1; logic [3:0] bp_a, bp_e;
      int bl = -1; logic [3:0] bl_a, bl_e;
      int br = -1; logic [3:0] br_a;
      logic [3:0] ep, el;
      settle(4'h0);
      n_checks++;
      if (btn_level !== 4'h0) $display("FAIL simul_pre_level: got %b want 0000", btn_level);
      else n_pass++;
      align_tick();
      btn_in = 4'b1010;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         ep = (i == 25) ? 4'b1010 : 4'b0000;
         el = (i >= 25) ? 4'b1010 : 4'b0000;
         if (btn_press !== ep && bp < 0) begin bp = i; bp_a = btn_press; bp_e = ep; end
         if (btn_level !== el && bl < 0) begin bl = i; bl_a = btn_level; bl_e = el; end
         if (btn_release !== 4'h0 && br < 0) begin br = i; br_a = btn_release; end
      end
      n_checks++;
      if (bp >= 0) $display("FAIL simul_press_seq @%0d: got %b want %b", bp, bp_a, bp_e);
      else n_pass++;
      n_checks++;
      if (bl >= 0) $display("FAIL simul_level @%0d: got %b want %b", bl, bl_a, bl_e);
      else n_pass++;
      n_checks++;
      if (br >= 0) $display("FAIL simul_release @%0d: got %b want 0000", br, br_a);
      else n_pass++;
   endtask

   task automatic test_reset_mid_qual();
      int bp = -1; logic [3:0] bp_a, bp_e;
      int bl = -1; logic [3:0] bl_a, bl_e;
      logic [3:0] ep, el;
      settle(4'h0);
      align_tick();
      btn_in = 4'b0100;
      for (int i = 1; i <= 48; i++) begin
         @(negedge clk);
         if (i == 18) begin
            n_checks++;
            if (tick_1ms !== 1'b0) $display("FAIL tick_mid_reset: got %b want 0", tick_1ms);
            else n_pass++;
         end
         if (i == 24) begin
            n_checks++;
            if (tick_1ms !== 1'b1) $display("FAIL tick_post_reset: got %b want 1", tick_1ms);
            else n_pass++;
         end
         ep = (i == 41) ? 4'b0100 : 4'b0000;
         el = (i >= 41) ? 4'b0100 : 4'b0000;
         if (btn_press !== ep && bp < 0) begin bp = i; bp_a = btn_press; bp_e = ep; end
         if (btn_level !== el && bl < 0) begin bl = i; bl_a = btn_level; bl_e = el; end
         if (i == 17) rst = 1'b1;
         if (i == 18) rst = 1'b0;
      end
      n_checks++;
      if (bp >= 0) $display("FAIL midreset_press_seq @%0d: got %b want %b", bp, bp_a, bp_e);
      else n_pass++;
      n_checks++;
      if (bl >= 0) $display("FAIL midreset_level @%0d: got %b want %b", bl, bl_a, bl_e);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid_qual();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout at %0t want completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
